// File: rtl/id_pipe_pkg.sv
// Shared encodings and the per-opcode operand routing table for the decode stage.
package id_pipe_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        OP1_ZERO,
        OP1_RS1,
        OP1_PC,
        OP1_UIMM
    } op1_sel_e;

    typedef enum logic [2:0] {
        OP2_ZERO,
        OP2_RS2,
        OP2_IMM_I,
        OP2_IMM_U,
        OP2_IMM_J
    } op2_sel_e;

    typedef struct packed {
        logic     use_rs1;
        logic     use_rs2;
        op1_sel_e op1_sel;
        op2_sel_e op2_sel;
        logic     wb;
        logic     is_csr;
        logic     illegal;
    } dec_ctrl_t;

    // Stores and branches carry rs1/rs2 as operands; their offsets are recovered downstream from inst_o.
    function automatic dec_ctrl_t decode_ctrl(input logic [31:0] inst);
        dec_ctrl_t c;
        c = '0;
        case (inst[6:0])
            OPC_OP_IMM: begin c.use_rs1 = 1'b1; c.op1_sel = OP1_RS1; c.op2_sel = OP2_IMM_I; c.wb = 1'b1; end
            OPC_OP: begin
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
                c.op1_sel = OP1_RS1; c.op2_sel = OP2_RS2; c.wb = 1'b1;
            end
            OPC_LUI:    begin c.op2_sel = OP2_IMM_U; c.wb = 1'b1; end
            OPC_AUIPC:  begin c.op1_sel = OP1_PC; c.op2_sel = OP2_IMM_U; c.wb = 1'b1; end
            OPC_STORE, OPC_BRANCH: begin
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
                c.op1_sel = OP1_RS1; c.op2_sel = OP2_RS2;
            end
            OPC_LOAD, OPC_JALR: begin
                c.use_rs1 = 1'b1; c.op1_sel = OP1_RS1; c.op2_sel = OP2_IMM_I; c.wb = 1'b1;
            end
            OPC_JAL:    begin c.op1_sel = OP1_PC; c.op2_sel = OP2_IMM_J; c.wb = 1'b1; end
            OPC_SYSTEM: begin
                case (inst[14:12])
                    F3_PRIV: ;
                    F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
                        c.use_rs1 = 1'b1; c.op1_sel = OP1_RS1; c.wb = 1'b1; c.is_csr = 1'b1;
                    end
                    F3_CSRRWI, F3_CSRRSI, F3_CSRRCI: begin
                        c.op1_sel = OP1_UIMM; c.wb = 1'b1; c.is_csr = 1'b1;
                    end
                    default: c.illegal = 1'b1;
                endcase
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_pipe_fwd_mux.sv
// One source operand: the youngest matching forwarding source wins, else regfile data; x0 reads zero.
module id_fwd_mux #(
    parameter int XLEN      = 32,
    parameter int FWD_PORTS = 2
) (
    input  logic [4:0]                raddr,
    input  logic [XLEN-1:0]           reg_rdata,
    input  logic [FWD_PORTS-1:0]      fwd_we,
    input  logic [5*FWD_PORTS-1:0]    fwd_waddr,
    input  logic [XLEN*FWD_PORTS-1:0] fwd_wdata,
    output logic [XLEN-1:0]           rdata
);

    // Walk from the oldest source to the youngest so the lowest index overrides.
    always_comb begin
        rdata = reg_rdata;
        for (int k = FWD_PORTS - 1; k >= 0; k--) begin
            if (fwd_we[k] && (fwd_waddr[5*k +: 5] == raddr)) begin
                rdata = fwd_wdata[XLEN*k +: XLEN];
            end
        end
        if (raddr == 5'd0) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/id_pipe.sv
// Decode stage: operand selection with forwarding, load-use and CSR hazards, one-entry output register.
module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int FWD_PORTS = 2,
    parameter int CSR_LAT   = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [31:0]               inst_i,
    input  logic [XLEN-1:0]           inst_addr_i,
    output logic [4:0]                reg1_raddr_o,
    output logic [4:0]                reg2_raddr_o,
    input  logic [XLEN-1:0]           reg1_rdata_i,
    input  logic [XLEN-1:0]           reg2_rdata_i,
    input  logic [FWD_PORTS-1:0]      fwd_we_i,
    input  logic [5*FWD_PORTS-1:0]    fwd_waddr_i,
    input  logic [XLEN*FWD_PORTS-1:0] fwd_wdata_i,
    input  logic                      fwd_is_load_i,
    input  logic                      flush_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [31:0]               inst_o,
    output logic [XLEN-1:0]           inst_addr_o,
    output logic [XLEN-1:0]           op1_o,
    output logic [XLEN-1:0]           op2_o,
    output logic                      reg_we_o,
    output logic [4:0]                reg_waddr_o,
    output logic                      csr_we_o,
    output logic                      csr_re_o,
    output logic [11:0]               csr_addr_o,
    output logic [1:0]                csr_op_o,
    output logic                      illegal_o,
    output logic                      stallreq_o
);

    localparam logic [3:0] CSR_LAT_W = 4'(CSR_LAT);

    logic [4:0]        rs1, rs2, rd;
    dec_ctrl_t         ctrl;
    logic [XLEN-1:0]   rs1_val, rs2_val, op1_d, op2_d;
    logic signed [31:0] imm_i, imm_u, imm_j;
    csr_op_e           csr_op_d;
    logic              csr_we_d, csr_re_d, load_use, hazard, transfer;
    logic [3:0]        csr_busy;

    assign rs1  = inst_i[19:15];
    assign rs2  = inst_i[24:20];
    assign rd   = inst_i[11:7];
    assign ctrl = decode_ctrl(inst_i);

    assign reg1_raddr_o = rs1;
    assign reg2_raddr_o = rs2;

    assign imm_i = 32'($signed(inst_i[31:20]));
    assign imm_u = {inst_i[31:12], 12'h000};
    assign imm_j = 32'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

    id_fwd_mux #(.XLEN(XLEN), .FWD_PORTS(FWD_PORTS)) u_fwd_rs1 (
        .raddr(rs1), .reg_rdata(reg1_rdata_i), .fwd_we(fwd_we_i),
        .fwd_waddr(fwd_waddr_i), .fwd_wdata(fwd_wdata_i), .rdata(rs1_val)
    );

    id_fwd_mux #(.XLEN(XLEN), .FWD_PORTS(FWD_PORTS)) u_fwd_rs2 (
        .raddr(rs2), .reg_rdata(reg2_rdata_i), .fwd_we(fwd_we_i),
        .fwd_waddr(fwd_waddr_i), .fwd_wdata(fwd_wdata_i), .rdata(rs2_val)
    );

    always_comb begin
        op1_d = '0;
        case (ctrl.op1_sel)
            OP1_RS1:  op1_d = rs1_val;
            OP1_PC:   op1_d = inst_addr_i;
            OP1_UIMM: op1_d = XLEN'(rs1);
            default:  op1_d = '0;
        endcase
        op2_d = '0;
        case (ctrl.op2_sel)
            OP2_RS2:   op2_d = rs2_val;
            OP2_IMM_I: op2_d = XLEN'(imm_i);
            OP2_IMM_U: op2_d = XLEN'(imm_u);
            OP2_IMM_J: op2_d = XLEN'(imm_j);
            default:   op2_d = '0;
        endcase
    end

    // Set/clear with a zero source must not write the CSR; a plain write with rd=x0 must not read it.
    assign csr_op_d = ctrl.is_csr ? csr_op_e'(inst_i[13:12]) : CSR_NONE;
    assign csr_we_d = ctrl.is_csr & ((inst_i[13:12] == 2'b01) | (rs1 != 5'd0));
    assign csr_re_d = ctrl.is_csr & ((inst_i[13:12] != 2'b01) | (rd != 5'd0));

    assign load_use = fwd_is_load_i & fwd_we_i[0] & (fwd_waddr_i[4:0] != 5'd0) &
                      ((ctrl.use_rs1 & (fwd_waddr_i[4:0] == rs1)) |
                       (ctrl.use_rs2 & (fwd_waddr_i[4:0] == rs2)));
    assign hazard     = valid_i & (load_use | (ctrl.is_csr & (csr_busy != 4'd0)));
    assign ready_o    = flush_i | ((~valid_o | ready_i) & ~hazard);
    assign stallreq_o = hazard & ~flush_i;
    assign transfer   = valid_i & ready_o & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o     <= 1'b0;
            inst_o      <= INST_NOP;
            inst_addr_o <= '0;
            op1_o       <= '0;
            op2_o       <= '0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= 5'd0;
            csr_we_o    <= 1'b0;
            csr_re_o    <= 1'b0;
            csr_addr_o  <= 12'h000;
            csr_op_o    <= CSR_NONE;
            illegal_o   <= 1'b0;
            csr_busy    <= 4'd0;
        end else begin
            if (flush_i) begin
                valid_o <= 1'b0;
            end else if (transfer) begin
                valid_o     <= 1'b1;
                inst_o      <= inst_i;
                inst_addr_o <= inst_addr_i;
                op1_o       <= op1_d;
                op2_o       <= op2_d;
                reg_we_o    <= ctrl.wb & (rd != 5'd0);
                reg_waddr_o <= rd;
                csr_we_o    <= csr_we_d;
                csr_re_o    <= csr_re_d;
                csr_addr_o  <= ctrl.is_csr ? inst_i[31:20] : 12'h000;
                csr_op_o    <= csr_op_d;
                illegal_o   <= ctrl.illegal;
            end else if (~valid_o | ready_i) begin
                valid_o <= 1'b0;
            end

            if (transfer & ctrl.is_csr) begin
                csr_busy <= CSR_LAT_W;
            end else if (csr_busy != 4'd0) begin
                csr_busy <= csr_busy - 4'd1;
            end
        end
    end

endmodule
